pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 52 +++++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Bundle between the pipeline datapath and the hazard
//                controller.
//                master : pipeline side. It drives the register indices,
//                         load/branch/memory status, and receives the enables.
//                slave  : controller side. It receives the status and drives
//                         the pipeline enables, flags and event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Instruction in IF/ID
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    // Instruction in ID/EX
    logic             ex_memread;
    logic [4:0]       ex_rd;
    // Redirect and memory status
    logic             branch_taken;
    logic             mem_busy;
    // Pipeline control
    logic             PCWrite;
    logic             IF_IDWrite;
    logic             IF_ID_flush;
    logic             ID_EX_bubble;
    logic             pipe_hold;
    // Status and debug
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             state;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_memread, ex_rd, branch_taken, mem_busy,
        input  PCWrite, IF_IDWrite, IF_ID_flush, ID_EX_bubble, pipe_hold,
               mem_timeout, stall_cnt, flush_cnt, state
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_memread, ex_rd, branch_taken, mem_busy,
        output PCWrite, IF_IDWrite, IF_ID_flush, ID_EX_bubble, pipe_hold,
               mem_timeout, stall_cnt, flush_cnt, state
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Hazard controller for a 5-stage pipeline. It detects
//                load-use hazards, squashes the pipeline on taken branches,
//                and freezes the pipeline while data memory is busy.
//                Ports:
//                  clk  - single clock, rising edge
//                  rst  - synchronous, active-high reset
//                  bus  - pipe_hazard_ctrl_if.slave. It carries the hazard
//                         inputs and drives the PCWrite, IF_IDWrite,
//                         IF_ID_flush, ID_EX_bubble and pipe_hold enables,
//                         plus mem_timeout, stall_cnt, flush_cnt and state.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 256
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [0:0]       c_RUN          = 1'b0;
    localparam logic [0:0]       c_MEMWAIT      = 1'b1;
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX      = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic             r_redirect_pend;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_load_use;
    logic w_redir;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_pipe_hold;

    // A write to x0 never creates a dependency.
    assign w_load_use = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                        ((bus.id_use_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                         (bus.id_use_rs2 && (bus.ex_rd == bus.id_rs2)));

    // A branch that resolved during a memory hold is remembered. It then
    // squashes on the first free cycle, even though the EX pulse is gone.
    assign w_redir = bus.branch_taken || r_redirect_pend;

    // Priority is memory hold, then redirect, then load-use.
    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_pipe_hold   = 1'b0;
        if (bus.mem_busy) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_pipe_hold  = 1'b1;
        end else if (w_redir) begin
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (w_load_use) begin
            // The load advances past EX on the next edge. This clears the
            // hazard by itself, so only one stall cycle occurs.
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_RUN;
            r_redirect_pend <= 1'b0;
            r_wait_cnt      <= '0;
            r_mem_timeout   <= 1'b0;
            r_stall_cnt     <= '0;
            r_flush_cnt     <= '0;
        end else begin
            if (bus.mem_busy) begin
                r_state         <= c_MEMWAIT;
                r_redirect_pend <= r_redirect_pend || bus.branch_taken;
                if (r_state == c_RUN) begin
                    r_wait_cnt <= '0;
                end else begin
                    if (r_wait_cnt == c_TIMEOUT_LAST) begin
                        r_mem_timeout <= 1'b1;
                    end
                    if (r_wait_cnt != c_CNT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
            end else begin
                // Leaving MEMWAIT costs no extra cycle. The redirect or
                // load-use action was already taken combinationally.
                r_state         <= c_RUN;
                r_redirect_pend <= 1'b0;
            end

            if (!w_pc_write && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_ifid_flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.PCWrite      = w_pc_write;
    assign bus.IF_IDWrite   = w_ifid_write;
    assign bus.IF_ID_flush  = w_ifid_flush;
    assign bus.ID_EX_bubble = w_idex_bubble;
    assign bus.pipe_hold    = w_pipe_hold;
    assign bus.mem_timeout  = r_mem_timeout;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;
    assign bus.state        = r_state[0];

endmodule
`default_nettype wire
